data_mem_lsu: RTL and testbench

Load/store unit that acts as the requester for the 16 kB byte-addressed data memory. It accepts single load/store requests from the execute stage over a valid/ready handshake and drives the memory's `rb`/`wb`/`adrb`/`din` port. It performs word and byte accesses, sign or zero extension on byte loads, and read-modify-write for byte stores, because the memory always writes both bytes. It returns one response per request, with an error flag for out-of-range addresses.

---
 rtl/data_mem_lsu_if.sv | 19 +
 rtl/data_mem_lsu.sv | 61 ++++++
 tb/tb_data_mem_lsu.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_lsu_if.sv
// data_mem_lsu_if: request/response handshake and data-memory port of the load/store unit
interface data_mem_lsu_if #(parameter int ADDR_W = 15);
  logic req_valid, req_ready, req_we, req_byte, req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [15:0] req_wdata;
  logic rsp_valid, rsp_ready, rsp_err;
  logic [15:0] rsp_rdata;
  logic mem_rb, mem_wb;
  logic [ADDR_W-1:0] mem_adrb;
  logic [15:0] mem_din, mem_dout;
  modport slave (
    input req_valid, req_we, req_byte, req_signed, req_addr, req_wdata, rsp_ready, mem_dout,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_rb, mem_wb, mem_adrb, mem_din
  );
  modport master (
    output req_valid, req_we, req_byte, req_signed, req_addr, req_wdata, rsp_ready, mem_dout,
    input req_ready, rsp_valid, rsp_rdata, rsp_err, mem_rb, mem_wb, mem_adrb, mem_din
  );
endinterface

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: load/store unit for the 16 kB data memory with byte-store read-modify-write
module data_mem_lsu #(
  parameter int ADDR_W = 15,
  parameter int MEM_BYTES = 16384
) (
  input logic clk,
  input logic rst,
  data_mem_lsu_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, RESP} state_t;
  state_t state, nxt;
  logic we, byt, sgn, err, legal, word_st;
  logic [ADDR_W-1:0] addr;
  logic [15:0] wdata, rdata;
  // a word also needs its second byte in range
  assign legal = ({1'b0, addr} + {{ADDR_W{1'b0}}, !byt}) < (ADDR_W+1)'(MEM_BYTES);
  assign word_st = we && !byt;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = bus.req_valid ? ISSUE : IDLE;
      ISSUE:   nxt = (!legal || word_st) ? RESP : WAIT;
      WAIT:    nxt = we ? WRITE : RESP;
      WRITE:   nxt = RESP;
      RESP:    nxt = bus.rsp_ready ? IDLE : RESP;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    bus.req_ready = state == IDLE && !rst;
    bus.rsp_valid = state == RESP;
    bus.mem_rb = state == ISSUE && legal && !word_st;
    bus.mem_wb = (state == ISSUE && legal && word_st) || state == WRITE;
    bus.mem_din = ((state == ISSUE && legal && word_st) || state == WRITE) ? wdata : '0;
  end
  assign bus.mem_adrb = addr;
  assign bus.rsp_rdata = rdata;
  assign bus.rsp_err = err;
  // wdata[15:8] doubles as the merge buffer for byte stores
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {we, byt, sgn, err} <= '0;
      addr <= '0;
      wdata <= '0;
      rdata <= '0;
    end else if (state == IDLE && bus.req_valid) begin
      {we, byt, sgn} <= {bus.req_we, bus.req_byte, bus.req_signed};
      addr <= bus.req_addr;
      wdata <= bus.req_wdata;
      err <= 1'b0;
      rdata <= '0;
    end else if (state == ISSUE) begin
      err <= !legal;
    end else if (state == WAIT) begin
      if (we) wdata[15:8] <= bus.mem_dout[15:8];
      else rdata <= byt ? {{8{sgn & bus.mem_dout[7]}}, bus.mem_dout[7:0]} : bus.mem_dout;
    end
endmodule

// File: tb/tb_data_mem_lsu.sv
// tb_data_mem_lsu: directed and random load/store transactions against a byte-array reference model
`timescale 1ns/1ps
module tb_data_mem_lsu;
  localparam int AW = 15, NB = 16384;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  data_mem_lsu_if #(.ADDR_W(AW)) bus();
  data_mem_lsu #(.ADDR_W(AW), .MEM_BYTES(NB)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 37 + 5) ^ 8'(i >> 6);
  endfunction

  logic [7:0] mem [NB];
  logic loaded = 0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < NB; i++) mem[i] <= pat(i);
      bus.mem_dout <= '0;
      loaded <= 1;
    end
    if (bus.mem_rb)
      bus.mem_dout <= {mem[(int'(bus.mem_adrb) + 1) % NB], mem[int'(bus.mem_adrb) % NB]};
    if (bus.mem_wb) begin
      mem[int'(bus.mem_adrb) % NB] <= bus.mem_din[7:0];
      if (int'(bus.mem_adrb) + 1 < NB) mem[int'(bus.mem_adrb) + 1] <= bus.mem_din[15:8];
    end
  end

  int cyc = 0, rb_n = 0, wb_n = 0, rb_cyc = -1, wb_cyc = -1;
  logic [15:0] last_din = 0;
  logic [AW-1:0] last_radr = 0, last_wadr = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.mem_rb) begin rb_n <= rb_n + 1; rb_cyc <= cyc; last_radr <= bus.mem_adrb; end
    if (bus.mem_wb) begin wb_n <= wb_n + 1; wb_cyc <= cyc; last_din <= bus.mem_din; last_wadr <= bus.mem_adrb; end
  end

  logic [7:0] ref_mem [NB];
  int checks = 0, errors = 0;
  logic [15:0] last_rdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic chk_bus();
    chk("strobe_excl", {31'b0, bus.mem_rb & bus.mem_wb}, 0);
    chk("din_idle", bus.mem_wb ? 32'h0 : {16'h0, bus.mem_din}, 0);
  endtask

  task automatic txn(input logic we, input logic byt, input logic sgn, input logic [AW-1:0] a,
                     input logic [15:0] wd, input int hold, input logic keep);
    logic ee;
    logic [15:0] er, edin;
    int v, lat, exp_lat, rb0, wb0, t1, erb, ewb;
    ee = byt ? (int'(a) >= NB) : (int'(a) + 1 >= NB);
    er = 0;
    if (!ee && !we) begin
      if (byt) begin
        v = int'(ref_mem[a]);
        if (sgn && v > 127) v -= 256;
        er = 16'(v);
      end else er = {ref_mem[a + 1], ref_mem[a]};
    end
    edin = byt ? {(int'(a) + 1 < NB) ? ref_mem[a + 1] : 8'h0, wd[7:0]} : wd;
    exp_lat = ee ? 2 : !we ? 3 : byt ? 4 : 2;
    erb = (!ee && (!we || byt)) ? 1 : 0;
    ewb = (!ee && we) ? 1 : 0;
    @(negedge clk);
    chk("req_ready_idle", {31'b0, bus.req_ready}, 1);
    {bus.req_we, bus.req_byte, bus.req_signed} = {we, byt, sgn};
    bus.req_addr = a;
    bus.req_wdata = wd;
    bus.req_valid = 1;
    rb0 = rb_n;
    wb0 = wb_n;
    t1 = 0;
    @(posedge clk); #1;
    if (!keep) bus.req_valid = 0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) t1 = cyc;
      chk_bus();
    end while (bus.rsp_valid !== 1'b1 && lat < 12);
    chk("latency", lat, exp_lat);
    chk("rdata", {16'h0, bus.rsp_rdata}, {16'h0, er});
    chk("err", {31'b0, bus.rsp_err}, {31'b0, ee});
    last_rdata = bus.rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      chk("hold_req_ready", {31'b0, bus.req_ready}, 0);
      @(negedge clk);
      chk_bus();
      chk("hold_valid", {31'b0, bus.rsp_valid}, 1);
      chk("hold_rdata", {16'h0, bus.rsp_rdata}, {16'h0, er});
      chk("hold_err", {31'b0, bus.rsp_err}, {31'b0, ee});
    end
    bus.rsp_ready = 1;
    @(posedge clk); #1;
    bus.rsp_ready = 0;
    bus.req_valid = 0;
    chk("rb_count", rb_n - rb0, erb);
    chk("wb_count", wb_n - wb0, ewb);
    if (erb == 1) begin
      chk("rb_time", rb_cyc, t1);
      chk("rb_addr", {17'h0, last_radr}, {17'h0, a});
    end
    if (ewb == 1) begin
      chk("wb_time", wb_cyc, byt ? t1 + 2 : t1);
      chk("wb_addr", {17'h0, last_wadr}, {17'h0, a});
      chk("wb_din", {16'h0, (byt && int'(a) + 1 >= NB) ? {8'h0, last_din[7:0]} : last_din}, {16'h0, edin});
    end
    if (!ee && we) begin
      ref_mem[a] = wd[7:0];
      if (!byt) ref_mem[a + 1] = wd[15:8];
    end
  endtask

  initial begin
    int bad, r;
    logic [AW-1:0] ra;
    for (int i = 0; i < NB; i++) ref_mem[i] = pat(i);
    {bus.req_valid, bus.req_we, bus.req_byte, bus.req_signed, bus.rsp_ready} = '0;
    bus.req_addr = 0;
    bus.req_wdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'b0, bus.req_ready}, 0);
    chk("rst_outs", {bus.rsp_valid, bus.rsp_err, bus.mem_rb, bus.mem_wb, bus.rsp_rdata, bus.mem_din}, 0);
    chk("rst_adrb", {17'h0, bus.mem_adrb}, 0);
    rst = 0;
    #1 chk("post_rst_ready", {31'b0, bus.req_ready}, 1);

    txn(1, 0, 0, 15'h0010, 16'hBEEF, 0, 0);
    txn(0, 0, 0, 15'h0010, 16'h0, 0, 0);
    chk("beef_load", {16'h0, last_rdata}, 32'hBEEF);
    chk("beef_bytes", {16'h0, mem[16'h10], mem[16'h11]}, 32'hEFBE);

    txn(1, 0, 0, 15'h0020, 16'h2211, 0, 0);
    txn(1, 1, 0, 15'h0021, 16'h55AB, 0, 0);
    txn(0, 0, 0, 15'h0020, 16'h0, 0, 0);
    chk("rmw_load", {16'h0, last_rdata}, 32'hAB11);

    txn(1, 1, 0, 15'h0030, 16'h0080, 0, 0);
    txn(0, 1, 1, 15'h0030, 16'h0, 0, 0);
    chk("sext", {16'h0, last_rdata}, 32'hFF80);
    txn(0, 1, 0, 15'h0030, 16'h0, 0, 0);
    chk("zext", {16'h0, last_rdata}, 32'h0080);
    txn(0, 0, 0, 15'h002F, 16'h0, 0, 0);
    chk("odd_word", {16'h0, last_rdata[15:8]}, 32'h80);

    txn(0, 0, 0, 15'h3FFF, 16'h0, 0, 0);
    txn(0, 1, 0, 15'h4000, 16'h0, 0, 0);
    txn(1, 0, 0, 15'h7FFE, 16'h1234, 0, 0);
    txn(0, 1, 1, 15'h3FFF, 16'h0, 0, 0);
    txn(1, 1, 0, 15'h3FFF, 16'h00C3, 0, 0);
    txn(0, 1, 0, 15'h3FFF, 16'h0, 0, 0);
    chk("top_byte", {16'h0, last_rdata}, 32'h00C3);

    txn(0, 0, 0, 15'h0010, 16'h0, 5, 1);
    txn(0, 0, 0, 15'h0020, 16'h0, 0, 0);

    @(negedge clk);
    {bus.req_we, bus.req_byte, bus.req_signed} = 3'b110;
    bus.req_addr = 15'h0100;
    bus.req_wdata = 16'h005A;
    bus.req_valid = 1;
    r = wb_n;
    @(posedge clk); #1;
    bus.req_valid = 0;
    @(negedge clk);
    chk("rst_issue_rb", {31'b0, bus.mem_rb}, 1);
    @(negedge clk);
    rst = 1;
    #1;
    chk("rst_mid_ready", {31'b0, bus.req_ready}, 0);
    chk("rst_mid_outs", {bus.rsp_valid, bus.rsp_err, bus.mem_rb, bus.mem_wb, bus.rsp_rdata, bus.mem_din}, 0);
    chk("rst_mid_adrb", {17'h0, bus.mem_adrb}, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    #1 chk("rst_mid_ready_after", {31'b0, bus.req_ready}, 1);
    repeat (3) @(negedge clk);
    chk("rst_mid_no_wb", wb_n - r, 0);
    chk("rst_mid_mem", {24'h0, mem[16'h100]}, {24'h0, ref_mem[16'h100]});

    for (int n = 0; n < 150; n++) begin
      r = int'($urandom_range(0, 9));
      ra = r < 5 ? 15'($urandom_range(0, 63)) : r < 8 ? 15'($urandom_range(16'h3FF8, 16'h3FFF)) : 15'($urandom);
      txn(1'($urandom), 1'($urandom), 1'($urandom), ra, 16'($urandom), int'($urandom_range(0, 2)), 0);
    end

    bad = 0;
    for (int i = 0; i < NB; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_image", bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
